// File: rtl/instr_decode.sv
// Decode stage feeding the 8-bit banked register file.
// It accepts 9-bit instructions over valid/ready, tracks the sticky bank bit,
// and registers the decoded fields for the register file and execute stage.
// It inserts a one-cycle bubble on load-use hazards and counts those bubbles.
module instr_decode #(
    parameter logic RESET_BANK     = 1'b0,
    parameter int   LOAD_USE_STALL = 1,
    parameter int   STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   instr_valid,
    input  logic [8:0]             instr,
    output logic                   instr_ready,
    input  logic                   ex_ready,
    output logic                   dec_valid,
    output logic [2:0]             operand1,
    output logic [2:0]             operand2,
    output logic                   D,
    output logic [3:0]             destination,
    output logic                   reg_write,
    output logic [1:0]             alu_op,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   branch,
    output logic                   halt,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [2:0] OP_LD      = 3'b100;
    localparam logic [2:0] OP_ST      = 3'b101;
    localparam logic [2:0] OP_BNZ     = 3'b110;
    localparam logic [2:0] OP_SPECIAL = 3'b111;

    localparam logic [2:0] SUB_BANK0 = 3'b000;
    localparam logic [2:0] SUB_BANK1 = 3'b001;
    localparam logic [2:0] SUB_HALT  = 3'b010;

    // Everything the output register carries besides the valid bit
    typedef struct packed {
        logic [2:0] op1;
        logic [2:0] op2;
        logic       d;
        logic [3:0] dest;
        logic       rw;
        logic [1:0] alu;
        logic       mr;
        logic       mw;
        logic       br;
    } dec_t;

    logic [2:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs;

    dec_t                   out_q, out_d;
    dec_t                   dec_new;
    logic                   dec_valid_q, dec_valid_d;
    logic                   bank_q, bank_d;
    logic                   halted_q, halted_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic is_special;
    logic slot_free;
    logic hazard;
    logic accept;
    logic stall_sat;

    assign opcode = instr[8:6];
    assign rd     = instr[5:3];
    assign rs     = instr[2:0];

    assign is_special = (opcode == OP_SPECIAL);

    // Decode the incoming instruction against the current bank bit.
    // LD/ST/BNZ use ADD encoding on alu_op (address/compare path).
    always_comb begin
        dec_new      = '0;
        dec_new.op1  = rd;
        dec_new.op2  = rs;
        dec_new.d    = bank_q;
        dec_new.dest = {bank_q, rd};
        dec_new.rw   = (opcode <= OP_LD);
        dec_new.alu  = opcode[2] ? 2'b00 : opcode[1:0];
        dec_new.mr   = (opcode == OP_LD);
        dec_new.mw   = (opcode == OP_ST);
        dec_new.br   = (opcode == OP_BNZ);
    end

    // Handshake and load-use hazard detection against the held LD.
    // The rs port always reads bank 0, so rs compares with a zero bank bit.
    always_comb begin
        slot_free   = !dec_valid_q || ex_ready;
        hazard      = (LOAD_USE_STALL != 0) && dec_valid_q && out_q.mr && instr_valid &&
                      !is_special &&
                      ((out_q.dest == {bank_q, rd}) || (out_q.dest == {1'b0, rs}));
        instr_ready = reset_n && !halted_q && slot_free && !hazard;
        accept      = instr_valid && instr_ready;
        stall_sat   = &stall_q;
    end

    // Next-state: accept, drain, bubble, and special-instruction side effects
    always_comb begin
        out_d       = out_q;
        dec_valid_d = dec_valid_q;
        bank_d      = bank_q;
        halted_d    = halted_q;
        stall_d     = stall_q;
        if (accept) begin
            if (is_special) begin
                // Specials never occupy the output; acceptance implies the slot is free
                dec_valid_d = 1'b0;
                case (rd)
                    SUB_BANK0: bank_d   = 1'b0;
                    SUB_BANK1: bank_d   = 1'b1;
                    SUB_HALT:  halted_d = 1'b1;
                    default:   ;
                endcase
            end else begin
                out_d       = dec_new;
                dec_valid_d = 1'b1;
            end
        end else if (dec_valid_q && ex_ready) begin
            // Drain with nothing behind it; fields hold, only valid drops
            dec_valid_d = 1'b0;
            if (hazard && !stall_sat) begin
                stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q       <= '0;
            dec_valid_q <= 1'b0;
            bank_q      <= RESET_BANK;
            halted_q    <= 1'b0;
            stall_q     <= '0;
        end else begin
            out_q       <= out_d;
            dec_valid_q <= dec_valid_d;
            bank_q      <= bank_d;
            halted_q    <= halted_d;
            stall_q     <= stall_d;
        end
    end

    assign dec_valid   = dec_valid_q;
    assign operand1    = out_q.op1;
    assign operand2    = out_q.op2;
    assign D           = out_q.d;
    assign destination = out_q.dest;
    assign reg_write   = out_q.rw;
    assign alu_op      = out_q.alu;
    assign mem_read    = out_q.mr;
    assign mem_write   = out_q.mw;
    assign branch      = out_q.br;
    assign halt        = halted_q;
    assign stall_count = stall_q;

endmodule
